vec_tile_buffer: RTL and testbench

- Downstream consumer of the vector DRAM loader.
- Captures each tile the loader pulses out (tile strobe plus ELEM_COUNT-element array) into a local register buffer of MAX_TILES entries.
- Marks the vector complete on the loader's done strobe, then serves 1-cycle-latency element reads to the compute datapath.
- Sits between the loader and the MAC/activation units.

---
 rtl/vec_tile_pkg.sv | 31 +++
 rtl/vtb_read_port.sv | 46 ++++
 rtl/vec_tile_buffer.sv | 135 +++++++++++++
 tb/tb_vec_tile_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_tile_pkg.sv
//============================================================================
// Module   : vec_tile_pkg
// Brief    : Shared types and helpers for the vector tile loader/buffer/store.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package vec_tile_pkg;

  localparam int VTB_ELEM_W = 8;

  typedef logic [VTB_ELEM_W-1:0] vtb_elem_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_READY   = 2'd2
  } vtb_state_e;

  // Plain constants for FSMs that keep a logic-typed state register.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILLING = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;

  function automatic int vtb_elem_count(input int tile_w, input int data_w);
    return tile_w / data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vtb_read_port.sv
//============================================================================
// Module   : vtb_read_port
// Brief    : Registered element read mux with tile range check and zero-fill.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module vtb_read_port #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_TILES  = 4,
  parameter int ELEM_COUNT = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_en,
  input  logic [$clog2(MAX_TILES)-1:0]  rd_tile_idx,
  input  logic [$clog2(ELEM_COUNT)-1:0] rd_elem_idx,
  input  logic                          is_ready,
  input  logic [$clog2(MAX_TILES+1)-1:0] tile_count,
  input  logic [DATA_WIDTH-1:0]         buffer [MAX_TILES][ELEM_COUNT],
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid
);

  localparam int c_cnt_w = $clog2(MAX_TILES + 1);

  logic w_hit;

  // Entries at or above tile_count may hold a previous vector's data.
  assign w_hit = is_ready && (c_cnt_w'(rd_tile_idx) < tile_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= w_hit ? buffer[rd_tile_idx][rd_elem_idx] : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_tile_buffer.sv
//============================================================================
// Module   : vec_tile_buffer
// Brief    : Captures loader tiles into a MAX_TILES register buffer and serves
//            1-cycle element reads once the vector is complete.
//            Optional: VTB_DROP_CNT_EN adds a saturating dropped-tile counter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module vec_tile_buffer
  import vec_tile_pkg::*;
#(
  parameter  int TILE_WIDTH = 256,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_TILES  = 4,
  localparam int ELEM_COUNT = vtb_elem_count(TILE_WIDTH, DATA_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           tile_in,
  input  logic [DATA_WIDTH-1:0]          tile_data [ELEM_COUNT],
  input  logic                           load_done,
  input  logic                           rd_en,
  input  logic [$clog2(MAX_TILES)-1:0]   rd_tile_idx,
  input  logic [$clog2(ELEM_COUNT)-1:0]  rd_elem_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [$clog2(MAX_TILES+1)-1:0] tile_count,
  output logic                           ready,
  output logic                           busy,
`ifdef VTB_DROP_CNT_EN
  output logic [7:0]                     drop_count,
`endif
  output logic                           overflow
);

  localparam int c_idx_w = $clog2(MAX_TILES);
  localparam int c_cnt_w = $clog2(MAX_TILES + 1);
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_TILES);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $fatal(1, "vec_tile_buffer: DATA_WIDTH must be 8");
  end
  if ((MAX_TILES < 2) || ((MAX_TILES & (MAX_TILES - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "vec_tile_buffer: MAX_TILES must be a power of two >= 2");
  end
  if ((TILE_WIDTH % DATA_WIDTH) != 0) begin : g_bad_tile_width
    $fatal(1, "vec_tile_buffer: TILE_WIDTH must be a multiple of DATA_WIDTH");
  end

  logic [1:0]            r_state;
  logic [c_cnt_w-1:0]    r_tile_count;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_buf [MAX_TILES][ELEM_COUNT];
  logic                  w_accept;
  logic                  w_store;

  assign w_accept = !start && (r_state == S_FILLING) && tile_in;
  assign w_store  = w_accept && (r_tile_count < c_max);

`ifdef VTB_DROP_CNT_EN
  logic [7:0] r_drop_count;
  assign drop_count = r_drop_count;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tile_count <= '0;
      r_overflow   <= 1'b0;
`ifdef VTB_DROP_CNT_EN
      r_drop_count <= 8'd0;
`endif
    end else if (start) begin
      r_state      <= S_FILLING;
      r_tile_count <= '0;
      r_overflow   <= 1'b0;
`ifdef VTB_DROP_CNT_EN
      r_drop_count <= 8'd0;
`endif
    end else if (r_state == S_FILLING) begin
      if (w_store) begin
        r_tile_count <= r_tile_count + 1'b1;
      end else if (w_accept) begin
        r_overflow <= 1'b1;
`ifdef VTB_DROP_CNT_EN
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
`endif
      end
      if (load_done) begin
        r_state <= S_READY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < MAX_TILES; t++) begin
        for (int e = 0; e < ELEM_COUNT; e++) begin
          r_buf[t][e] <= '0;
        end
      end
    end else if (w_store) begin
      r_buf[r_tile_count[c_idx_w-1:0]] <= tile_data;
    end
  end

  vtb_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_TILES  (MAX_TILES),
    .ELEM_COUNT (ELEM_COUNT)
  ) u_read_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .rd_tile_idx (rd_tile_idx),
    .rd_elem_idx (rd_elem_idx),
    .is_ready    (r_state == S_READY),
    .tile_count  (r_tile_count),
    .buffer      (r_buf),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  assign tile_count = r_tile_count;
  assign overflow   = r_overflow;
  assign ready      = (r_state == S_READY);
  assign busy       = (r_state == S_FILLING);

endmodule

`default_nettype wire

// File: tb/tb_vec_tile_buffer.sv
//============================================================================
// Module   : tb_vec_tile_buffer
// Brief    : Directed self-checking bench for vec_tile_buffer.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_vec_tile_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       tile_in;
  logic [7:0] tile_data [32];
  logic       load_done;
  logic       rd_en;
  logic [1:0] rd_tile_idx;
  logic [4:0] rd_elem_idx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] tile_count;
  logic       ready;
  logic       busy;
  logic       overflow;
`ifdef VTB_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vec_tile_buffer #(
    .TILE_WIDTH (256),
    .DATA_WIDTH (8),
    .MAX_TILES  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tile_in     (tile_in),
    .tile_data   (tile_data),
    .load_done   (load_done),
    .rd_en       (rd_en),
    .rd_tile_idx (rd_tile_idx),
    .rd_elem_idx (rd_elem_idx),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .tile_count  (tile_count),
    .ready       (ready),
    .busy        (busy),
`ifdef VTB_DROP_CNT_EN
    .drop_count  (drop_count),
`endif
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < 32; i++) tile_data[i] = base + 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 32; i++) tile_data[i] = v;
  endtask

  task automatic read_req(input logic [1:0] t, input logic [4:0] e);
    rd_en = 1'b1;
    rd_tile_idx = t;
    rd_elem_idx = e;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tile_in = 1'b0; load_done = 1'b0;
    rd_en = 1'b0; rd_tile_idx = '0; rd_elem_idx = '0;
    fill_const(8'h00);
    #12;
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", tile_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rdd", rd_data, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Two tiles, second one coincident with load_done
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_count0", tile_count, 0);
    fill_seq(8'h00); tile_in = 1'b1; tick();
    check("t1_count1", tile_count, 1);
    fill_seq(8'h80); load_done = 1'b1; tick();
    tile_in = 1'b0; load_done = 1'b0;
    check("t1_count2", tile_count, 2);
    check("t1_ready", ready, 1);
    check("t1_busy_off", busy, 0);
    read_req(2'd1, 5'd5);
    check("t1_rdv", rd_valid, 1);
    check("t1_rdd", rd_data, 8'h85);
    tick();
    check("t1_rdv_idle", rd_valid, 0);
    check("t1_rdd_hold", rd_data, 8'h85);

    // Out-of-range tile reads as zero, in-range last element
    read_req(2'd3, 5'd0);
    check("t3_oor_v", rd_valid, 1);
    check("t3_oor_d", rd_data, 0);
    read_req(2'd0, 5'd31);
    check("t3_t0e31_v", rd_valid, 1);
    check("t3_t0e31_d", rd_data, 8'h1F);

    // Back-to-back reads
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rd_tile_idx = 2'd1; rd_elem_idx = 5'(i);
      tick();
      check($sformatf("t6_v%0d", i), rd_valid, 1);
      check($sformatf("t6_d%0d", i), rd_data, 32'h80 + i);
    end
    rd_en = 1'b0; tick();
    check("t6_v_end", rd_valid, 0);
    check("t6_d_hold", rd_data, 8'h9F);

    // Asynchronous reset during FILLING
    start = 1'b1; tick(); start = 1'b0;
    fill_seq(8'hA0); tile_in = 1'b1; tick(); tile_in = 1'b0;
    check("t4_pre_count", tile_count, 1);
    #2; rst_n = 1'b0; #1;
    check("t4_busy", busy, 0);
    check("t4_ready", ready, 0);
    check("t4_count", tile_count, 0);
    check("t4_ovf", overflow, 0);
    check("t4_rdd", rd_data, 0);
    check("t4_rdv", rd_valid, 0);
    #1; rst_n = 1'b1;
    tile_in = 1'b1; tick(); tile_in = 1'b0;
    check("t4_idle_count", tile_count, 0);
    check("t4_idle_busy", busy, 0);
    read_req(2'd0, 5'd0);
    check("t4_rd_v", rd_valid, 1);
    check("t4_rd_d", rd_data, 0);

    // Overflow: five tiles into four entries
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_seq(8'(k * 16)); tile_in = 1'b1; tick();
      check($sformatf("t2_count%0d", k + 1), tile_count, k + 1);
    end
    check("t2_ovf_pre", overflow, 0);
    fill_const(8'hFF); tick(); tile_in = 1'b0;
    check("t2_count_full", tile_count, 4);
    check("t2_ovf", overflow, 1);
    check("t2_busy", busy, 1);
    load_done = 1'b1; tick(); load_done = 1'b0;
    check("t2_ready", ready, 1);
    check("t2_count_ready", tile_count, 4);
`ifdef VTB_DROP_CNT_EN
    check("t2_drop", drop_count, 1);
`endif
    read_req(2'd3, 5'd7);
    check("t2_t3_d", rd_data, 8'h37);
    tile_in = 1'b1; tick(); tile_in = 1'b0;
    check("t2_ready_tile_count", tile_count, 4);

    // start in READY with concurrent read and tile
    start = 1'b1; tile_in = 1'b1; fill_const(8'h55);
    rd_en = 1'b1; rd_tile_idx = 2'd3; rd_elem_idx = 5'd7;
    tick();
    start = 1'b0; tile_in = 1'b0; rd_en = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_ready", ready, 0);
    check("t5_count", tile_count, 0);
    check("t5_ovf", overflow, 0);
    check("t5_prestart_v", rd_valid, 1);
    check("t5_prestart_d", rd_data, 8'h37);
`ifdef VTB_DROP_CNT_EN
    check("t5_drop", drop_count, 0);
`endif
    read_req(2'd0, 5'd7);
    check("t5_fill_v", rd_valid, 1);
    check("t5_fill_d", rd_data, 0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    check("t5_ready2", ready, 1);
    check("t5_count2", tile_count, 0);
    read_req(2'd0, 5'd7);
    check("t5_stale_d", rd_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
